// File: rtl/btn_if.sv
// Button bus between the raw pins and the conditioned outputs.
interface btn_if #(
    parameter int unsigned N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_db;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;

    modport master (
        output btn_raw,
        input  btn_db,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_db,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, per-bit debounce FSM,
// registered active-low level and one-cycle press/release strobes.
module btn_conditioner #(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic  clk,
    input  logic  rst_n,
    btn_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REL   = 2'd0,
        CHK_P = 2'd1,
        PRS   = 2'd2,
        CHK_R = 2'd3
    } state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    state_t           state     [N_BTN];
    state_t           state_nxt [N_BTN];
    logic [CNT_W-1:0] cnt       [N_BTN];
    logic [CNT_W-1:0] cnt_nxt   [N_BTN];

    logic [N_BTN-1:0] db_q;
    logic [N_BTN-1:0] db_nxt;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] press_nxt;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] release_nxt;

    // Two-stage synchronizer; idles at "released" so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;
        end
    end

    // FSM state, counters, debounced level and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                state[i] <= REL;
                cnt[i]   <= '0;
            end
            db_q      <= '1;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            db_q      <= db_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
        end
    end

    // Per-bit debounce: a change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_nxt      = db_q;
        press_nxt   = '0;
        release_nxt = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                REL: begin
                    if (!sync2[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_nxt[i] = PRS;
                            cnt_nxt[i]   = '0;
                            db_nxt[i]    = 1'b0;
                            press_nxt[i] = 1'b1;
                        end else begin
                            state_nxt[i] = CHK_P;
                            cnt_nxt[i]   = CNT_W'(1);
                        end
                    end else begin
                        cnt_nxt[i] = '0;
                    end
                end
                CHK_P: begin
                    if (sync2[i]) begin
                        state_nxt[i] = REL;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = PRS;
                        cnt_nxt[i]   = '0;
                        db_nxt[i]    = 1'b0;
                        press_nxt[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                PRS: begin
                    if (sync2[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_nxt[i]   = REL;
                            cnt_nxt[i]     = '0;
                            db_nxt[i]      = 1'b1;
                            release_nxt[i] = 1'b1;
                        end else begin
                            state_nxt[i] = CHK_R;
                            cnt_nxt[i]   = CNT_W'(1);
                        end
                    end else begin
                        cnt_nxt[i] = '0;
                    end
                end
                CHK_R: begin
                    if (!sync2[i]) begin
                        state_nxt[i] = PRS;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i]   = REL;
                        cnt_nxt[i]     = '0;
                        db_nxt[i]      = 1'b1;
                        release_nxt[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt[i] = REL;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    assign bus.btn_db        = db_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with DEBOUNCE_CYCLES=4: directed scenarios with
// edge-exact expectations, then random bouncing checked against a run-length model.
module tb_btn_conditioner;
    localparam int unsigned N = 3;
    localparam int unsigned D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    btn_if #(.N_BTN(N)) bus ();

    btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: two-sample delay, then a level flips once it has
    // disagreed with the synchronized input for D samples in a row.
    logic [N-1:0] m_s1, m_s2, m_db, m_pp, m_rp;
    int           m_run [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1; m_db = '1; m_pp = '0; m_rp = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            m_pp = '0;
            m_rp = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        m_db[i]  = m_s2[i];
                        m_pp[i]  = ~m_s2[i];
                        m_rp[i]  = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bus.btn_raw;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [N-1:0] exp_db, exp_pp;
        bus.btn_raw = 3'b000;
        rst_n = 1'b0;
        idle(3);
        n_tests++;
        if (bus.btn_db !== 3'b111 || bus.press_pulse !== 3'b000 || bus.release_pulse !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_hold: db=%b pp=%b rp=%b, expected db=111 pp=000 rp=000",
                     bus.btn_db, bus.press_pulse, bus.release_pulse);
        end
        rst_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk); #1;
            exp_db = (e >= 5) ? 3'b000 : 3'b111;
            exp_pp = (e == 5) ? 3'b111 : 3'b000;
            n_tests++;
            if (bus.btn_db !== exp_db || bus.press_pulse !== exp_pp || bus.release_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: db=%b pp=%b rp=%b, expected db=%b pp=%b rp=000",
                         e, bus.btn_db, bus.press_pulse, bus.release_pulse, exp_db, exp_pp);
            end
        end
        @(negedge clk);
        bus.btn_raw = 3'b111;
        idle(10);
        n_tests++;
        if (bus.btn_db !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_settle: db=%b, expected 111", bus.btn_db);
        end
    endtask

    task automatic test_clean_press;
        logic [N-1:0] exp_db, exp_pp;
        @(negedge clk);
        bus.btn_raw[0] = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk); #1;
            exp_db = (e >= 5) ? 3'b110 : 3'b111;
            exp_pp = (e == 5) ? 3'b001 : 3'b000;
            n_tests++;
            if (bus.btn_db !== exp_db || bus.press_pulse !== exp_pp || bus.release_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL clean_press edge %0d: db=%b pp=%b rp=%b, expected db=%b pp=%b rp=000",
                         e, bus.btn_db, bus.press_pulse, bus.release_pulse, exp_db, exp_pp);
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.btn_db !== 3'b110 || bus.press_pulse !== 3'b000 || bus.release_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL hold cycle %0d: db=%b pp=%b rp=%b, expected db=110 pp=000 rp=000",
                         c, bus.btn_db, bus.press_pulse, bus.release_pulse);
            end
        end
    endtask

    task automatic test_bounce;
        logic [N-1:0] exp_db, exp_pp;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.btn_raw[1] = (k % 2 == 1);
            repeat (2) begin
                @(posedge clk); #1;
                n_tests++;
                if (bus.btn_db !== 3'b110 || bus.press_pulse !== 3'b000) begin
                    n_fail++;
                    $display("FAIL bounce_phase %0d: db=%b pp=%b, expected db=110 pp=000",
                             k, bus.btn_db, bus.press_pulse);
                end
            end
        end
        @(negedge clk);
        bus.btn_raw[1] = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk); #1;
            exp_db = (e >= 5) ? 3'b100 : 3'b110;
            exp_pp = (e == 5) ? 3'b010 : 3'b000;
            n_tests++;
            if (bus.btn_db !== exp_db || bus.press_pulse !== exp_pp) begin
                n_fail++;
                $display("FAIL bounce_settle edge %0d: db=%b pp=%b, expected db=%b pp=%b",
                         e, bus.btn_db, bus.press_pulse, exp_db, exp_pp);
            end
        end
        @(negedge clk);
        bus.btn_raw[1] = 1'b1;
        idle(10);
        n_tests++;
        if (bus.btn_db !== 3'b110) begin
            n_fail++;
            $display("FAIL bounce_release: db=%b, expected 110", bus.btn_db);
        end
    endtask

    task automatic test_glitch;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.btn_db !== 3'b110 || bus.press_pulse !== 3'b000 || bus.release_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL glitch cycle %0d: db=%b pp=%b rp=%b, expected db=110 pp=000 rp=000",
                         c, bus.btn_db, bus.press_pulse, bus.release_pulse);
            end
            if (c == 0) bus.btn_raw[2] = 1'b0;
            if (c == 3) bus.btn_raw[2] = 1'b1;
        end
    endtask

    task automatic test_release;
        logic [N-1:0] exp_db, exp_rp;
        @(negedge clk);
        bus.btn_raw[0] = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk); #1;
            exp_db = (e >= 5) ? 3'b111 : 3'b110;
            exp_rp = (e == 5) ? 3'b001 : 3'b000;
            n_tests++;
            if (bus.btn_db !== exp_db || bus.release_pulse !== exp_rp || bus.press_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL release edge %0d: db=%b pp=%b rp=%b, expected db=%b pp=000 rp=%b",
                         e, bus.btn_db, bus.press_pulse, bus.release_pulse, exp_db, exp_rp);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [N-1:0] exp_db, exp_pp;
        @(negedge clk);
        bus.btn_raw[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.btn_db !== 3'b111 || bus.press_pulse !== 3'b000 || bus.release_pulse !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_in_chk_p: db=%b pp=%b rp=%b, expected db=111 pp=000 rp=000",
                     bus.btn_db, bus.press_pulse, bus.release_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk); #1;
            exp_db = (e >= 5) ? 3'b110 : 3'b111;
            exp_pp = (e == 5) ? 3'b001 : 3'b000;
            n_tests++;
            if (bus.btn_db !== exp_db || bus.press_pulse !== exp_pp || bus.release_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL requalify edge %0d: db=%b pp=%b rp=%b, expected db=%b pp=%b rp=000",
                         e, bus.btn_db, bus.press_pulse, bus.release_pulse, exp_db, exp_pp);
            end
        end
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.btn_db !== 3'b111 || bus.press_pulse !== 3'b000 || bus.release_pulse !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_in_prs: db=%b pp=%b rp=%b, expected db=111 pp=000 rp=000",
                     bus.btn_db, bus.press_pulse, bus.release_pulse);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bus.release_pulse !== 3'b000 || bus.press_pulse !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_quiet cycle %0d: pp=%b rp=%b, expected 000/000",
                         c, bus.press_pulse, bus.release_pulse);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (bus.btn_db !== 3'b111 || bus.press_pulse !== 3'b000) begin
            n_fail++;
            $display("FAIL requalify2_early: db=%b pp=%b, expected db=111 pp=000",
                     bus.btn_db, bus.press_pulse);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.btn_db !== 3'b110 || bus.press_pulse !== 3'b001) begin
            n_fail++;
            $display("FAIL requalify2_edge5: db=%b pp=%b, expected db=110 pp=001",
                     bus.btn_db, bus.press_pulse);
        end
        @(negedge clk);
        bus.btn_raw = 3'b111;
        idle(12);
        n_tests++;
        if (bus.btn_db !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_reset_settle: db=%b, expected 111", bus.btn_db);
        end
    endtask

    task automatic test_random;
        int           hold [N];
        logic [N-1:0] raw;
        raw = bus.btn_raw;
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.btn_db !== m_db || bus.press_pulse !== m_pp || bus.release_pulse !== m_rp) begin
                n_fail++;
                $display("FAIL random cycle %0d: db=%b pp=%b rp=%b, expected db=%b pp=%b rp=%b",
                         c, bus.btn_db, bus.press_pulse, bus.release_pulse, m_db, m_pp, m_rp);
            end
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    raw[i]  = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3))
                                                           : int'($urandom_range(5, 12));
                end else begin
                    hold[i] = hold[i] - 1;
                end
            end
            bus.btn_raw = raw;
        end
    endtask

    initial begin
        bus.btn_raw = 3'b111;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
